// File: rtl/spe_omem_port.sv
// ============================================================================
// Module      : spe_omem_port
// Description : SPE-side port to the output memory. Forwards computed
//               potentials/spikes to the OMEM, fetches the previous-timestep
//               residue on request, and tracks timestep-done broadcasts.
//               Optional macro SPE_OMEM_PORT_STATS_EN adds per-timestep
//               write/request handshake counters (wr_cnt, req_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spe_omem_port #(
  parameter int SPE_ID    = 0,
  parameter int OMEM_ADDR = 11,
  parameter int SUM_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_req_valid,
  output logic                 core_req_ready,
  output logic                 core_resid_valid,
  input  logic                 core_resid_ready,
  output logic [SUM_WIDTH-1:0] core_resid,
  input  logic                 core_wr_valid,
  output logic                 core_wr_ready,
  input  logic [SUM_WIDTH-1:0] core_wr_potential,
  input  logic                 core_wr_spike,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [32:0]          tx_packet,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [32:0]          rx_packet,
  output logic [1:0]           ts,
  output logic                 ts_done,
  output logic                 bad_pkt
`ifdef SPE_OMEM_PORT_STATS_EN
  ,
  output logic [8:0]           wr_cnt,
  output logic [8:0]           req_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_TX    = 3'd1,
    WAIT_RESP = 3'd2,
    RESID_OUT = 3'd3,
    WR_TX     = 3'd4
  } state_t;

  localparam logic [3:0] c_DEST    = 4'(OMEM_ADDR);
  localparam logic [3:0] c_OP_SEND = 4'(2 * SPE_ID);
  localparam logic [3:0] c_OP_REQ  = 4'(2 * SPE_ID + 1);
  localparam logic [3:0] c_OP_TS   = 4'd15;

  state_t               state_q, state_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [32:0]          tx_packet_q, tx_packet_d;
  logic                 resid_valid_q, resid_valid_d;
  logic [SUM_WIDTH-1:0] resid_q, resid_d;
  logic [1:0]           ts_q, ts_d;
  logic                 ts_done_q, ts_done_d;
  logic                 bad_pkt_q, bad_pkt_d;

  logic                 rx_fire;
  logic                 rx_is_ts;
  logic                 tx_fire;
  logic                 unused_rx_bits;

  // Handshake qualifiers; readies are forced low while reset is held.
  assign rx_fire        = rx_valid & rx_ready;
  assign rx_is_ts       = (rx_packet[28:25] == c_OP_TS);
  assign tx_fire        = tx_valid_q & tx_ready;
  // Write wins arbitration, so the request is not acknowledged alongside it.
  assign core_wr_ready  = rst_n & (state_q == IDLE);
  assign core_req_ready = rst_n & (state_q == IDLE) & ~core_wr_valid;
  assign rx_ready       = rst_n & (state_q != RESID_OUT);
  // Destination and upper data bits of received packets carry no meaning here.
  assign unused_rx_bits = ^{rx_packet[32:29], rx_packet[24:SUM_WIDTH]};

  assign tx_valid         = tx_valid_q;
  assign tx_packet        = tx_packet_q;
  assign core_resid_valid = resid_valid_q;
  assign core_resid       = resid_q;
  assign ts               = ts_q;
  assign ts_done          = ts_done_q;
  assign bad_pkt          = bad_pkt_q;

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_valid_q    <= 1'b0;
      tx_packet_q   <= '0;
      resid_valid_q <= 1'b0;
      resid_q       <= '0;
      ts_q          <= 2'd1;
      ts_done_q     <= 1'b0;
      bad_pkt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_valid_q    <= tx_valid_d;
      tx_packet_q   <= tx_packet_d;
      resid_valid_q <= resid_valid_d;
      resid_q       <= resid_d;
      ts_q          <= ts_d;
      ts_done_q     <= ts_done_d;
      bad_pkt_q     <= bad_pkt_d;
    end
  end

  // Next-state logic for the transaction FSM and the timestep tracker.
  always_comb begin
    state_d       = state_q;
    tx_valid_d    = tx_valid_q;
    tx_packet_d   = tx_packet_q;
    resid_valid_d = resid_valid_q;
    resid_d       = resid_q;
    ts_d          = ts_q;
    ts_done_d     = 1'b0;
    bad_pkt_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_wr_valid) begin
          state_d     = WR_TX;
          tx_valid_d  = 1'b1;
          tx_packet_d = {c_DEST, c_OP_SEND, 24'(core_wr_potential), core_wr_spike};
        end else if (core_req_valid) begin
          state_d     = REQ_TX;
          tx_valid_d  = 1'b1;
          tx_packet_d = {c_DEST, c_OP_REQ, 25'd0};
        end
      end
      WR_TX: begin
        if (tx_fire) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      REQ_TX: begin
        if (tx_fire) begin
          state_d    = WAIT_RESP;
          tx_valid_d = 1'b0;
        end
      end
      WAIT_RESP: begin
        if (rx_fire && !rx_is_ts) begin
          state_d       = RESID_OUT;
          resid_valid_d = 1'b1;
          resid_d       = rx_packet[SUM_WIDTH-1:0];
        end
      end
      RESID_OUT: begin
        if (core_resid_ready) begin
          state_d       = IDLE;
          resid_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = IDLE;
        tx_valid_d    = 1'b0;
        resid_valid_d = 1'b0;
      end
    endcase

    // Timestep broadcasts are honoured in any state; stray data is dropped.
    if (rx_fire) begin
      if (rx_is_ts) begin
        ts_done_d = 1'b1;
        ts_d      = 2'd2;
      end else if (state_q != WAIT_RESP) begin
        bad_pkt_d = 1'b1;
      end
    end
  end

`ifdef SPE_OMEM_PORT_STATS_EN
  logic [8:0] wr_cnt_q;
  logic [8:0] req_cnt_q;

  // Per-timestep handshake counters, cleared when a timestep-done is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      req_cnt_q <= '0;
    end else if (rx_fire && rx_is_ts) begin
      wr_cnt_q  <= '0;
      req_cnt_q <= '0;
    end else if (tx_fire) begin
      if (state_q == WR_TX)  wr_cnt_q  <= wr_cnt_q + 9'd1;
      if (state_q == REQ_TX) req_cnt_q <= req_cnt_q + 9'd1;
    end
  end

  assign wr_cnt  = wr_cnt_q;
  assign req_cnt = req_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_spe_omem_port.sv
// ============================================================================
// Module      : tb_spe_omem_port
// Description : Directed self-checking bench for spe_omem_port. Two instances
//               (SPE_ID 3 and 2) share stimulus so both opcode mappings are
//               exercised. Stats checks compile when SPE_OMEM_PORT_STATS_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spe_omem_port;

  logic        clk;
  logic        rst_n;
  logic        core_req_valid, core_resid_ready, core_wr_valid, core_wr_spike;
  logic [12:0] core_wr_potential;
  logic        tx_ready, rx_valid;
  logic [32:0] rx_packet;

  logic        core_req_ready, core_resid_valid, core_wr_ready;
  logic [12:0] core_resid;
  logic        tx_valid, rx_ready, ts_done, bad_pkt;
  logic [32:0] tx_packet;
  logic [1:0]  ts;

  logic        b_req_ready, b_resid_valid, b_wr_ready;
  logic [12:0] b_resid;
  logic        b_tx_valid, b_rx_ready, b_ts_done, b_bad_pkt;
  logic [32:0] b_tx_packet;
  logic [1:0]  b_ts;

`ifdef SPE_OMEM_PORT_STATS_EN
  logic [8:0]  wr_cnt, req_cnt, b_wr_cnt, b_req_cnt;
`endif

  int errors = 0;
  int checks = 0;

  spe_omem_port #(.SPE_ID(3), .OMEM_ADDR(11), .SUM_WIDTH(13)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_resid_valid(core_resid_valid), .core_resid_ready(core_resid_ready),
    .core_resid(core_resid),
    .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
    .core_wr_potential(core_wr_potential), .core_wr_spike(core_wr_spike),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_packet(tx_packet),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_packet(rx_packet),
    .ts(ts), .ts_done(ts_done), .bad_pkt(bad_pkt)
`ifdef SPE_OMEM_PORT_STATS_EN
    , .wr_cnt(wr_cnt), .req_cnt(req_cnt)
`endif
  );

  spe_omem_port #(.SPE_ID(2), .OMEM_ADDR(11), .SUM_WIDTH(13)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(b_req_ready),
    .core_resid_valid(b_resid_valid), .core_resid_ready(core_resid_ready),
    .core_resid(b_resid),
    .core_wr_valid(core_wr_valid), .core_wr_ready(b_wr_ready),
    .core_wr_potential(core_wr_potential), .core_wr_spike(core_wr_spike),
    .tx_valid(b_tx_valid), .tx_ready(tx_ready), .tx_packet(b_tx_packet),
    .rx_valid(rx_valid), .rx_ready(b_rx_ready), .rx_packet(rx_packet),
    .ts(b_ts), .ts_done(b_ts_done), .bad_pkt(b_bad_pkt)
`ifdef SPE_OMEM_PORT_STATS_EN
    , .wr_cnt(b_wr_cnt), .req_cnt(b_req_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    core_req_valid = 0; core_resid_ready = 0; core_wr_valid = 0; core_wr_spike = 0;
    core_wr_potential = '0; tx_ready = 0; rx_valid = 0; rx_packet = '0;

    // Reset values, asserted before any clock edge.
    #2 rst_n = 1'b0;
    #2;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_packet", tx_packet, 0);
    check("rst_ts", ts, 1);
    check("rst_resid_valid", core_resid_valid, 0);
    check("rst_req_ready", core_req_ready, 0);
    check("rst_wr_ready", core_wr_ready, 0);
    check("rst_rx_ready", rx_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_req_ready", core_req_ready, 1);
    check("idle_wr_ready", core_wr_ready, 1);
    check("idle_rx_ready", rx_ready, 1);

    // Write potential=100 spike=1 with tx_ready high.
    core_wr_valid = 1; core_wr_potential = 13'd100; core_wr_spike = 1; tx_ready = 1;
    tick();
    core_wr_valid = 0;
    check("wr_tx_valid", tx_valid, 1);
    check("wr_pkt_id3", tx_packet, {4'd11, 4'd6, 25'd201});
    check("wr_pkt_id2", b_tx_packet, {4'd11, 4'd4, 25'd201});
    check("wr_busy_req_ready", core_req_ready, 0);
    tick();
    check("wr_done_tx_valid", tx_valid, 0);
    check("wr_done_tx_valid_b", b_tx_valid, 0);
    tx_ready = 0;

    // Request, then residue 57 returned.
    core_req_valid = 1;
    tick();
    core_req_valid = 0;
    check("req_tx_valid", tx_valid, 1);
    check("req_pkt_id3", tx_packet, {4'd11, 4'd7, 25'd0});
    tx_ready = 1;
    tick();
    tx_ready = 0;
    check("req_done_tx_valid", tx_valid, 0);
    rx_packet = {4'd3, 4'd7, 25'd57}; rx_valid = 1;
    check("wait_rx_ready", rx_ready, 1);
    tick();
    rx_valid = 0;
    check("resid_valid", core_resid_valid, 1);
    check("resid_value", core_resid, 57);
    check("resid_rx_ready", rx_ready, 0);
    tick();
    check("resid_hold", core_resid_valid, 1);
    core_resid_ready = 1;
    tick();
    core_resid_ready = 0;
    check("resid_done", core_resid_valid, 0);
    check("resid_back_idle", core_req_ready, 1);

    // Timestep-done arrives while waiting for a response.
    core_req_valid = 1; tx_ready = 1;
    tick();
    core_req_valid = 0;
    tick();
    tx_ready = 0;
    rx_packet = {4'd0, 4'd15, 25'd0}; rx_valid = 1;
    tick();
    rx_valid = 0;
    check("tsd_pulse", ts_done, 1);
    check("tsd_ts2", ts, 2);
    check("tsd_no_resid", core_resid_valid, 0);
    check("tsd_still_wait", rx_ready, 1);
    tick();
    check("tsd_pulse_end", ts_done, 0);
    rx_packet = {4'd3, 4'd7, 25'd9}; rx_valid = 1;
    tick();
    rx_valid = 0;
    check("tsd_resid_valid", core_resid_valid, 1);
    check("tsd_resid_value", core_resid, 9);
    core_resid_ready = 1;
    tick();
    core_resid_ready = 0;

    // Stray data packet in IDLE, then a second timestep-done at ts=2.
    rx_packet = {4'd0, 4'd6, 25'd5}; rx_valid = 1;
    tick();
    rx_valid = 0;
    check("bad_pulse", bad_pkt, 1);
    check("bad_still_idle", core_req_ready, 1);
    check("bad_no_resid", core_resid_valid, 0);
    tick();
    check("bad_pulse_end", bad_pkt, 0);
    rx_packet = {4'd0, 4'd15, 25'd0}; rx_valid = 1;
    tick();
    rx_valid = 0;
    check("ts_sat_pulse", ts_done, 1);
    check("ts_sat_value", ts, 2);

    // Simultaneous write and request with tx backpressure.
    core_wr_valid = 1; core_req_valid = 1; core_wr_potential = 13'd5; core_wr_spike = 0;
    #1;
    check("arb_req_ready", core_req_ready, 0);
    check("arb_wr_ready", core_wr_ready, 1);
    tick();
    core_wr_valid = 0;
    check("arb_wr_pkt", tx_packet, {4'd11, 4'd6, 25'd10});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("arb_hold_valid", tx_valid, 1);
      check("arb_hold_pkt", tx_packet, {4'd11, 4'd6, 25'd10});
    end
    tx_ready = 1;
    tick();
    check("arb_idle_req_ready", core_req_ready, 1);
    tick();
    core_req_valid = 0;
    check("arb_req_pkt", tx_packet, {4'd11, 4'd7, 25'd0});
    tick();
    tx_ready = 0;
    check("arb_wait", tx_valid, 0);

    // Reset mid-wait after ts=2: transaction abandoned, ts back to 1.
    check("pre_rst_ts", ts, 2);
    rst_n = 0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_ts", ts, 1);
    check("mid_rst_rx_ready", rx_ready, 0);
    tick();
    rst_n = 1;
    tick();
    check("post_rst_idle", core_req_ready, 1);
    rx_packet = {4'd3, 4'd7, 25'd44}; rx_valid = 1;
    tick();
    rx_valid = 0;
    check("post_rst_stray", bad_pkt, 1);
    check("post_rst_no_resid", core_resid_valid, 0);

`ifdef SPE_OMEM_PORT_STATS_EN
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      core_wr_valid = 1;
      tick();
      core_wr_valid = 0;
      tick();
    end
    check("stats_wr3", wr_cnt, 3);
    check("stats_req0", req_cnt, 0);
    rx_packet = {4'd0, 4'd15, 25'd0}; rx_valid = 1;
    tick();
    rx_valid = 0;
    check("stats_wr_clr", wr_cnt, 0);
    tx_ready = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
